// File: rtl/rice_encoder_packer_if.sv
// Valid/ready symbol input and packed-word output bundle of the Rice encoder packer.
interface rice_encoder_packer_if #(
    parameter int W_VAL = 16,
    parameter int W_OUT = 32,
    parameter int K_MAX = 8
);
    localparam int KW = $clog2(K_MAX + 1);

    logic             in_valid;
    logic             in_ready;
    logic [W_VAL-1:0] in_val;
    logic [KW-1:0]    in_k;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] out_word;
    logic             out_last;

    modport master (
        output in_valid, in_val, in_k, in_flush, out_ready,
        input  in_ready, out_valid, out_word, out_last
    );

    modport slave (
        input  in_valid, in_val, in_k, in_flush, out_ready,
        output in_ready, out_valid, out_word, out_last
    );
endinterface

// File: rtl/rice_encoder_packer.sv
// Rice encoder: unary prefix (escaped to raw bits when long), terminator, remainder, packed MSB-first.
// Optional stat_bits_o/stat_escapes_o counters exist only when RICE_ENC_STATS_EN is defined.
module rice_encoder_packer #(
    parameter int W_VAL = 16,
    parameter int W_OUT = 32,
    parameter int K_MAX = 8,
    parameter int Q_ESC = 24
) (
    input  logic clk_i,
    input  logic rst_i,
    rice_encoder_packer_if.slave bus
`ifdef RICE_ENC_STATS_EN
    ,
    output logic [31:0] stat_bits_o,
    output logic [15:0] stat_escapes_o
`endif
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int CW = $clog2(W_OUT + 1);

    // states: IDLE wait request | PREFIX ones | SUFFIX zero+remainder | ESC raw value | FLUSH pad out
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREFIX = 3'd1;
    localparam logic [2:0] S_SUFFIX = 3'd2;
    localparam logic [2:0] S_ESC    = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [W_OUT-1:0] acc_q, acc_d;
    logic             esc_q, esc_d;
    logic [KW-1:0]    k_q, k_d;
    logic [W_VAL-1:0] r_q, r_d;
    logic [W_VAL-1:0] raw_q, raw_d;
    logic             out_valid_q, out_valid_d;
    logic [W_OUT-1:0] out_word_q, out_word_d;
    logic             out_last_q, out_last_d;

    logic [KW-1:0]    k_eff;
    logic [W_VAL-1:0] q_in, r_in;
    logic             q_is_esc, accept, appending, fld_done;
    logic [CW-1:0]    space, n_bits, fill_add;
    logic [W_OUT-1:0] fld, chunk, placed, acc_app;

    assign k_eff    = (bus.in_k > KW'(K_MAX)) ? KW'(K_MAX) : bus.in_k;
    assign q_in     = bus.in_val >> k_eff;
    assign r_in     = bus.in_val & ~({W_VAL{1'b1}} << k_eff);
    assign q_is_esc = (int'(q_in) >= Q_ESC);

    assign bus.in_ready  = (state_q == S_IDLE) && !out_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_last  = out_last_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign appending = !out_valid_q &&
                       (state_q == S_PREFIX || state_q == S_SUFFIX || state_q == S_ESC);

    // Take the next n_bits of the current field (counted down by rem_q) and drop them below fill.
    assign space    = CW'(W_OUT) - fill_q;
    assign n_bits   = (rem_q < space) ? rem_q : space;
    assign chunk    = (fld >> (rem_q - n_bits)) & ({W_OUT{1'b1}} >> (CW'(W_OUT) - n_bits));
    assign placed   = chunk << (space - n_bits);
    assign acc_app  = acc_q | placed;
    assign fill_add = fill_q + n_bits;
    assign fld_done = (rem_q == n_bits);

    always_comb begin
        fld = '0;
        case (state_q)
            S_PREFIX: fld = '1;
            S_SUFFIX: fld = W_OUT'(r_q);
            S_ESC:    fld = W_OUT'(raw_q);
            default:  fld = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        esc_d       = esc_q;
        k_d         = k_q;
        r_d         = r_q;
        raw_d       = raw_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            fill_d      = '0;
            acc_d       = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.in_flush) begin
                        state_d = S_FLUSH;
                    end else begin
                        k_d   = k_eff;
                        r_d   = r_in;
                        raw_d = bus.in_val;
                        esc_d = q_is_esc;
                        if (q_is_esc) begin
                            rem_d   = CW'(Q_ESC);
                            state_d = S_PREFIX;
                        end else if (q_in != '0) begin
                            rem_d   = CW'(q_in);
                            state_d = S_PREFIX;
                        end else begin
                            rem_d   = CW'(k_eff) + CW'(1);
                            state_d = S_SUFFIX;
                        end
                    end
                end
            end
            S_PREFIX, S_SUFFIX, S_ESC: begin
                if (appending) begin
                    acc_d  = acc_app;
                    fill_d = fill_add;
                    rem_d  = rem_q - n_bits;
                    if (fill_add == CW'(W_OUT)) begin
                        out_valid_d = 1'b1;
                        out_word_d  = acc_app;
                        out_last_d  = 1'b0;
                    end
                    if (fld_done) begin
                        if (state_q == S_PREFIX && esc_q) begin
                            state_d = S_ESC;
                            rem_d   = CW'(W_VAL);
                        end else if (state_q == S_PREFIX) begin
                            state_d = S_SUFFIX;
                            rem_d   = CW'(k_q) + CW'(1);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (out_valid_q) begin
                    if (bus.out_ready) state_d = S_IDLE;
                end else if (fill_q != '0) begin
                    out_valid_d = 1'b1;
                    out_word_d  = acc_q;
                    out_last_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            fill_q      <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            esc_q       <= 1'b0;
            k_q         <= '0;
            r_q         <= '0;
            raw_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            esc_q       <= esc_d;
            k_q         <= k_d;
            r_q         <= r_d;
            raw_q       <= raw_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef RICE_ENC_STATS_EN
    logic [31:0] stat_bits_q, stat_bits_d;
    logic [15:0] stat_esc_q, stat_esc_d;
    logic [32:0] bits_sum;

    assign bits_sum = {1'b0, stat_bits_q} + 33'(n_bits);

    always_comb begin
        stat_bits_d = stat_bits_q;
        stat_esc_d  = stat_esc_q;
        if (appending) stat_bits_d = bits_sum[32] ? '1 : bits_sum[31:0];
        if (accept && !bus.in_flush && q_is_esc && stat_esc_q != '1)
            stat_esc_d = stat_esc_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_bits_q <= '0;
            stat_esc_q  <= '0;
        end else begin
            stat_bits_q <= stat_bits_d;
            stat_esc_q  <= stat_esc_d;
        end
    end

    assign stat_bits_o    = stat_bits_q;
    assign stat_escapes_o = stat_esc_q;
`endif
endmodule

// File: tb/tb_rice_encoder_packer.sv
// Bench for rice_encoder_packer: fixed vectors, hand-built corner sequences, random traffic vs a bit-queue model.
module tb_rice_encoder_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rice_encoder_packer_if #(.W_VAL(16), .W_OUT(32), .K_MAX(8)) bus ();

`ifdef RICE_ENC_STATS_EN
    logic [31:0] stat_bits;
    logic [15:0] stat_esc;
`endif

    rice_encoder_packer #(.W_VAL(16), .W_OUT(32), .K_MAX(8), .Q_ESC(24)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef RICE_ENC_STATS_EN
        ,
        .stat_bits_o    (stat_bits),
        .stat_escapes_o (stat_esc)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [32:0] got[$];   // {last, word} as seen on the output handshake
    logic [32:0] expq[$];  // same, predicted by the model
    bit          pend[$];  // code bits not yet forming a full word
    int          m_bits = 0;
    int          m_esc  = 0;
    bit          rnd_ready = 1'b0;

    typedef struct {
        int               n_syms;
        logic [7:0][15:0] vals;
        logic [7:0][3:0]  ks;
        int               n_exp;
        logic [1:0][31:0] words;
        logic [1:0]       lasts;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) pend.push_back(v[i]);
        m_bits += len;
        while (pend.size() >= 32) begin
            logic [31:0] w = '0;
            for (int i = 31; i >= 0; i--) w[i] = pend.pop_front();
            expq.push_back({1'b0, w});
        end
    endtask

    task automatic model_sym(input logic [15:0] v, input logic [3:0] k);
        int kk = (k > 8) ? 8 : int'(k);
        int q  = int'(v) >> kk;
        int r  = int'(v) % (1 << kk);
        if (q >= 24) begin
            for (int i = 0; i < 24; i++) push_bits(32'd1, 1);
            push_bits({16'd0, v}, 16);
            m_esc++;
        end else begin
            for (int i = 0; i < q; i++) push_bits(32'd1, 1);
            push_bits(32'd0, 1);
            push_bits(32'(r), kk);
        end
    endtask

    task automatic model_flush();
        if (pend.size() > 0) begin
            logic [31:0] w = '0;
            int n = pend.size();
            for (int i = 0; i < n; i++) w[31-i] = pend.pop_front();
            expq.push_back({1'b1, w});
        end
    endtask

    task automatic model_reset();
        pend.delete();
        expq.delete();
        m_bits = 0;
        m_esc  = 0;
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] k, input bit fl);
        int t = 0;
        bit ok = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_val   = v;
        bus.in_k     = k;
        bus.in_flush = fl;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (++t > 2000) begin
                checks++; failures++; ok = 1'b0;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (ok) begin
            if (fl) model_flush();
            else    model_sym(v, k);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (++t > 2000) begin
                checks++; failures++;
                $display("FAIL idle_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
                break;
            end
        end
    endtask

    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready) got.push_back({bus.out_last, bus.out_word});

    always @(posedge clk) begin
        #1;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1, '0, '0, 1, '0, '0};
        vt[0].vals[0] = 16'd13;   vt[0].ks[0] = 4'd2;
        vt[0].words[0] = 32'hE4000000; vt[0].lasts[0] = 1'b1;
        vt[1] = '{1, '0, '0, 2, '0, '0};
        vt[1].vals[0] = 16'd40;   vt[1].ks[0] = 4'd0;
        vt[1].words[0] = 32'hFFFFFF00; vt[1].lasts[0] = 1'b0;
        vt[1].words[1] = 32'h28000000; vt[1].lasts[1] = 1'b1;
        vt[2] = '{8, '0, '0, 1, '0, '0};
        for (int i = 0; i < 8; i++) begin vt[2].vals[i] = 16'd5; vt[2].ks[i] = 4'd3; end
        vt[2].words[0] = 32'h55555555; vt[2].lasts[0] = 1'b0;
        vt[3] = '{1, '0, '0, 1, '0, '0};
        vt[3].vals[0] = 16'd0;    vt[3].ks[0] = 4'd1;
        vt[3].words[0] = 32'h00000000; vt[3].lasts[0] = 1'b1;
        vt[4] = '{1, '0, '0, 1, '0, '0};
        vt[4].vals[0] = 16'h01FF; vt[4].ks[0] = 4'd15;
        vt[4].words[0] = 32'hBFC00000; vt[4].lasts[0] = 1'b1;
        vt[5] = '{1, '0, '0, 1, '0, '0};
        vt[5].vals[0] = 16'd23;   vt[5].ks[0] = 4'd0;
        vt[5].words[0] = 32'hFFFFFE00; vt[5].lasts[0] = 1'b1;
        vt[6] = '{1, '0, '0, 2, '0, '0};
        vt[6].vals[0] = 16'd24;   vt[6].ks[0] = 4'd0;
        vt[6].words[0] = 32'hFFFFFF00; vt[6].lasts[0] = 1'b0;
        vt[6].words[1] = 32'h18000000; vt[6].lasts[1] = 1'b1;

        bus.in_valid  = 1'b0;
        bus.in_val    = '0;
        bus.in_k      = '0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b1;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_out_word",  64'(bus.out_word),  64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef RICE_ENC_STATS_EN
        check("rst_stat_bits", 64'(stat_bits), 64'd0);
        check("rst_stat_esc",  64'(stat_esc),  64'd0);
`endif

        for (int v = 0; v < 7; v++) begin
            got.delete();
            for (int i = 0; i < vt[v].n_syms; i++) send(vt[v].vals[i], vt[v].ks[i], 1'b0);
            send(16'd0, 4'd0, 1'b1);
            wait_idle();
            check($sformatf("vec%0d_count", v), 64'(got.size()), 64'(vt[v].n_exp));
            for (int j = 0; j < vt[v].n_exp && j < got.size(); j++) begin
                check($sformatf("vec%0d_word%0d", v, j), 64'(got[j][31:0]), 64'(vt[v].words[j]));
                check($sformatf("vec%0d_last%0d", v, j), 64'(got[j][32]), 64'(vt[v].lasts[j]));
            end
        end
        expq.delete();

        // a full word held under backpressure must stay put and block new symbols
        got.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd5, 4'd3, 1'b0);
        begin
            int t = 0;
            while (!bus.out_valid && t < 50) begin @(negedge clk); t++; end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_word",  64'(bus.out_word),  64'h55555555);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        check("bp_no_handshake", 64'(got.size()), 64'd0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        send(16'd13, 4'd2, 1'b0);
        send(16'd0, 4'd0, 1'b1);
        wait_idle();
        check("bp_count", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            check("bp_word0", 64'(got[0]), {31'd0, 1'b0, 32'h55555555});
            check("bp_word1", 64'(got[1]), {31'd0, 1'b1, 32'hE4000000});
        end
        expq.delete();
`ifdef RICE_ENC_STATS_EN
        check("stat_bits_a", 64'(stat_bits), 64'(m_bits));
        check("stat_esc_a",  64'(stat_esc),  64'(m_esc));
`endif

        // reset while the prefix of a symbol is pending in a partly filled word
        got.delete();
        send(16'd13, 4'd2, 1'b0);
        send(16'd20, 4'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("mid_rst_no_out", 64'(got.size()), 64'd0);
        check("mid_rst_valid",  64'(bus.out_valid), 64'd0);
        send(16'd0, 4'd1, 1'b0);
        send(16'd0, 4'd0, 1'b1);
        wait_idle();
        check("mid_rst_count", 64'(got.size()), 64'd1);
        if (got.size() == 1)
            check("mid_rst_word", 64'(got[0]), {31'd0, 1'b1, 32'h00000000});
        expq.delete();

        // random symbols, flushes and output stalls against the bit-queue model
        got.delete();
        rnd_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                send(16'd0, 4'd0, 1'b1);
            end else begin
                logic [15:0] v = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
                logic [3:0]  k = 4'($urandom_range(0, 15));
                send(v, k, 1'b0);
            end
        end
        send(16'd0, 4'd0, 1'b1);
        wait_idle();
        rnd_ready = 1'b0;
        @(posedge clk); #1 bus.out_ready = 1'b1;
        check("rnd_count", 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            check($sformatf("rnd_word%0d", i), 64'(got[i]), 64'(expq[i]));
`ifdef RICE_ENC_STATS_EN
        check("stat_bits_b", 64'(stat_bits), 64'(m_bits));
        check("stat_esc_b",  64'(stat_esc),  64'(m_esc));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rice_encoder_packer.md
Name: rice_encoder_packer

Overview:
- Encode side of the Rice-coded bitstream; the decode path uses leading-one counting to recover unary prefixes.
- Takes one unsigned value plus a per-symbol k. Emits a unary prefix of q = val >> k ones, a terminating zero, and the k-bit remainder.
- Bounded prefix with an escape to raw value bits.
- Packs code bits MSB-first into fixed-width words behind valid/ready handshakes on both sides.

Parameters:
- W_VAL, 16, input value width in bits.
- W_OUT, 32, output word width in bits; must be at least W_VAL and at least K_MAX+1.
- K_MAX, 8, largest supported Rice parameter.
- Q_ESC, 24, prefix length that signals an escape; must be less than W_OUT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  symbol or flush request valid.
- in_ready  out  1  block accepts the request this cycle.
- in_val  in  W_VAL  value to encode; ignored when in_flush is high.
- in_k  in  $clog2(K_MAX+1)  Rice parameter; a value above K_MAX is treated as K_MAX.
- in_flush  in  1  request is a flush, not a symbol.
- out_valid  out  1  out_word holds a complete word.
- out_ready  in  1  consumer takes the word.
- out_word  out  W_OUT  packed code bits; the first emitted bit is at bit W_OUT-1.
- out_last  out  1  word is the padded final word produced by a flush.

Behaviour:
- Reset: state IDLE, fill=0, accumulator=0, out_valid=0, out_last=0, out_word=0, in_ready=1 in the cycle after rst deasserts. Reset mid-operation discards the pending symbol and any partial word without emitting it.
- States: IDLE, PREFIX, SUFFIX, ESC, FLUSH.
- in_ready = (state==IDLE) && !out_valid.
- Accept (in_valid && in_ready, in_flush=0):
  - Latch q = in_val >> k, r = in_val & ((1<<k)-1), k, and raw value.
  - q >= Q_ESC: prefix length = Q_ESC, next state PREFIX with escape flag set.
  - Otherwise prefix length = q; next state PREFIX if q>0, else SUFFIX.
- Append engine, one chunk per cycle while out_valid=0:
  - Chunk size = min(remaining field bits, W_OUT-fill), placed at the next-lower accumulator bits.
  - PREFIX appends ones. When the prefix is complete: ESC if the escape flag is set, else SUFFIX.
  - SUFFIX appends {1'b0, r[k-1:0]}, i.e. 1+k bits.
  - ESC appends W_VAL raw value bits MSB-first, with no terminator.
  - The field-complete transition returns to IDLE.
- Word full:
  - When an append makes fill==W_OUT, out_word is loaded and out_valid=1 on the next cycle. Appending stalls.
  - On out_valid && out_ready: fill=0, accumulator=0, out_valid=0 next cycle, appending resumes.
  - A field split across words continues exactly at the bit where it stopped.
- Backpressure: out_word and out_last hold stable while out_valid && !out_ready.
- Flush (accept with in_flush=1): enter FLUSH.
  - If fill>0: zero-pad the low bits, present the word with out_last=1, and return to IDLE after the handshake.
  - If fill==0: no word is emitted, return to IDLE next cycle.
- Code length per symbol: q+1+k bits, or Q_ESC+W_VAL bits for an escape. A symbol occupies at least 2 cycles (latch plus at least one append).
- Both handshakes are independent. A word handshake and a new in_ready can never coincide in the same cycle, because in_ready requires !out_valid.

Optional Feature:
- Macro RICE_ENC_STATS_EN.
- When defined, the block adds two ports and two counters, both cleared by rst and saturating at all-ones:
  - output stat_bits[31:0]: total code bits appended, excluding flush padding.
  - output stat_escapes[15:0]: number of escaped symbols.
- When undefined, neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset: rst high 2 cycles, then low -> out_valid=0, out_last=0, in_ready=1; with stats enabled, stat_bits=0.
- val=13, k=2, then flush -> one word 0xE4000000, out_last=1; code bits 111 0 01.
- val=40, k=0 (q=40 >= 24, escape), then flush -> 0xFFFFFF00 with out_last=0, then 0x28000000 with out_last=1; stat_escapes=1.
- Eight symbols val=5, k=3 (code 0101 each), then flush -> one word 0x55555555 with out_last=0; flush emits no word.
- Backpressure: out_ready=0 for 5 cycles with a full word pending -> out_word stable, in_ready=0, no bits lost; release gives the correct next word.
- rst pulse while in PREFIX mid-word -> no output; the next symbol val=0, k=1 plus flush gives 0x00000000 with out_last=1.
